// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared playfield constants and bomb FSM state encoding
package bomberman_pkg;

  localparam int unsigned MIN_X  = 143;
  localparam int unsigned MAX_X  = 784;
  localparam int unsigned MIN_Y  = 34;
  localparam int unsigned MAX_Y  = 516;
  localparam int unsigned TILE_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPLODE = 2'd2
  } bomb_state_t;

endpackage

// File: rtl/tile_snap.sv
// rtl/tile_snap.sv - rounds one 10-bit pixel coordinate to the nearest tile origin and clamps it
module tile_snap
  import bomberman_pkg::*;
#(
  parameter int unsigned AXIS_MIN = MIN_X,
  parameter int unsigned AXIS_MAX = MAX_X
) (
  input  logic [9:0] coord,
  output logic [9:0] snapped
);

  localparam logic [10:0] LIMIT     = 11'(AXIS_MAX - TILE_W);
  localparam logic [9:0]  TILE_MASK = ~10'(TILE_W - 1);

  logic [9:0]  offset;
  logic [10:0] sum;

  // The sum is widened so a tile past the right/bottom edge clamps instead of wrapping.
  always_comb begin
    offset  = (coord - 10'(AXIS_MIN) + 10'(TILE_W / 2)) & TILE_MASK;
    sum     = {1'b0, offset} + 11'(AXIS_MIN);
    snapped = (sum > LIMIT) ? LIMIT[9:0] : sum[9:0];
  end

endmodule

// File: rtl/bomb_controller.sv
// rtl/bomb_controller.sv - single-bomb placement, fuse and explosion sequencer (BOMB_REMOTE_DET_EN: press while armed detonates early)
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int unsigned FUSE_CYCLES    = 150000000,
  parameter int unsigned EXPLODE_CYCLES = 50000000,
  parameter int unsigned CNT_W          = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c,
  input  logic       game_over,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       bomb_active,
  output logic [9:0] bomb_x,
  output logic [9:0] bomb_y,
  output logic       explosion_active,
  output logic       explosion_scen,
  output logic [9:0] e_x,
  output logic [9:0] e_y
);

  localparam logic [CNT_W-1:0] FUSE_LAST    = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPLODE_LAST = CNT_W'(EXPLODE_CYCLES - 1);

  bomb_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             c_q;
  logic             press;
  logic             remote_det;
  logic [9:0]       snap_x, snap_y;
  logic [9:0]       bomb_x_n, bomb_y_n, e_x_n, e_y_n;
  logic             scen_n;

  assign press = c && !c_q;

`ifdef BOMB_REMOTE_DET_EN
  assign remote_det = press;
`else
  assign remote_det = 1'b0;
`endif

  tile_snap #(.AXIS_MIN(MIN_X), .AXIS_MAX(MAX_X)) u_snap_x (.coord(b_x), .snapped(snap_x));
  tile_snap #(.AXIS_MIN(MIN_Y), .AXIS_MAX(MAX_Y)) u_snap_y (.coord(b_y), .snapped(snap_y));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bomb_x_n = bomb_x;
    bomb_y_n = bomb_y;
    e_x_n    = e_x;
    e_y_n    = e_y;
    scen_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (press && !game_over) begin
          state_n  = ARMED;
          cnt_n    = '0;
          bomb_x_n = snap_x;
          bomb_y_n = snap_y;
        end
      end
      ARMED: begin
        // game_over is deliberately not consulted: a placed bomb always finishes.
        if (cnt == FUSE_LAST || remote_det) begin
          state_n = EXPLODE;
          cnt_n   = '0;
          scen_n  = 1'b1;
          e_x_n   = bomb_x;
          e_y_n   = bomb_y;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      EXPLODE: begin
        if (cnt == EXPLODE_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      c_q              <= 1'b0;
      bomb_active      <= 1'b0;
      explosion_active <= 1'b0;
      explosion_scen   <= 1'b0;
      bomb_x           <= 10'(MIN_X);
      bomb_y           <= 10'(MIN_Y);
      e_x              <= 10'(MIN_X);
      e_y              <= 10'(MIN_Y);
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      c_q              <= c;
      bomb_active      <= (state_n != IDLE);
      explosion_active <= (state_n == EXPLODE);
      explosion_scen   <= scen_n;
      bomb_x           <= bomb_x_n;
      bomb_y           <= bomb_y_n;
      e_x              <= e_x_n;
      e_y              <= e_y_n;
    end
  end

endmodule

// File: doc/bomb_controller.md
# bomb_controller

Sequences the single bomb available to the player. It captures a placement request from the bomb button and snaps the bomb to the 16-pixel tile grid. It runs the fuse timer, then drives the explosion coordinates and the one-cycle explosion pulse consumed by the player-movement/death logic and the explosion renderer. It sits between the top module's debounced button inputs and every block that consumes `e_x`, `e_y` and the explosion pulse.

## Interface
- `FUSE_CYCLES`, 150000000: clock cycles spent in ARMED (1.5 s at 100 MHz).
- `EXPLODE_CYCLES`, 50000000: clock cycles spent in EXPLODE.
- `CNT_W`, 28: width of the shared phase counter; must hold max(FUSE_CYCLES, EXPLODE_CYCLES).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `c`  in  1  bomb button level, debounced and synchronous to `clk`.
- `game_over`  in  1  player dead; blocks new placements.
- `b_x`, `b_y`  in  10 each  player sprite top-left pixel.
- `bomb_active`  out  1  bomb is placed (ARMED or EXPLODE).
- `bomb_x`, `bomb_y`  out  10 each  snapped bomb tile top-left pixel.
- `explosion_active`  out  1  high for the whole EXPLODE phase.
- `explosion_scen`  out  1  single-cycle pulse on the first EXPLODE cycle.
- `e_x`, `e_y`  out  10 each  explosion centre tile; equal to `bomb_x`/`bomb_y` during EXPLODE.

## Operation
- States: IDLE, ARMED, EXPLODE.
- `c_q` is a registered copy of `c`. A press is `c && !c_q`, a rising edge only; holding the button never re-triggers.
- Snap rule, 10-bit unsigned:
  - `bomb_x = MIN_X + ((b_x - MIN_X + 8) & ~15)`.
  - `bomb_y = MIN_Y + ((b_y - MIN_Y + 8) & ~15)`.
  - This is round-to-nearest tile.
  - Results are clamped to at most `MAX_X-16` and `MAX_Y-16` respectively.
- IDLE → ARMED on press && !game_over. Latch the snapped coordinates and load the counter with 0.
- ARMED: the counter increments each cycle. When counter == FUSE_CYCLES-1, go to EXPLODE and clear the counter.
- EXPLODE: `explosion_scen` is high in the first cycle only. `e_x`/`e_y` hold the latched tile. When counter == EXPLODE_CYCLES-1, go to IDLE.
- Presses in ARMED or EXPLODE are ignored (unless the macro below is defined).
- game_over asserting mid-sequence does not abort it. The bomb completes its fuse and explosion; only new placements are blocked.
- Reset outputs:
  - `bomb_active`, `explosion_active`, `explosion_scen` = 0.
  - `bomb_x`, `e_x` = MIN_X.
  - `bomb_y`, `e_y` = MIN_Y.
  - State = IDLE, counter = 0, `c_q` = 0.
- Reset mid-operation returns immediately to IDLE with these values; no pulse is emitted.

## Timing
- Press sampled at edge t: state is ARMED and `bomb_active`=1 after edge t.
- ARMED lasts exactly FUSE_CYCLES cycles.
- `explosion_scen` is high for exactly the cycle after the last ARMED cycle.
- EXPLODE lasts exactly EXPLODE_CYCLES cycles.
- `bomb_active` falls together with `explosion_active`.
- A press in the first IDLE cycle after EXPLODE is accepted (no cooldown).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `BOMB_REMOTE_DET_EN` defined: a press (rising edge) while ARMED forces the transition to EXPLODE at the next edge, with normal `explosion_scen` and duration. game_over does not block this detonation.
- Undefined: presses in ARMED are ignored and the fuse always runs the full FUSE_CYCLES.

## Structure
- Shared package `bomberman_pkg`:
  - Constants MIN_X=143, MAX_X=784, MIN_Y=34, MAX_Y=516, TILE_W=16.
  - State encoding for IDLE/ARMED/EXPLODE.
- Sub-module `tile_snap`: combinational snap-and-clamp of one 10-bit coordinate, parameterised by axis minimum and maximum, instantiated twice.
- The phase counter and FSM live in `bomb_controller`.

## Test plan
All scenarios use FUSE_CYCLES=10, EXPLODE_CYCLES=4.
- Basic sequence:
  - Stimulus: reset, then press with b_x=150, b_y=34.
  - Response: bomb_x=143, bomb_y=34; bomb_active for 14 cycles; explosion_scen high exactly once, 10 cycles after the press is accepted; e_x=143, e_y=34.
- Rounding: b_x=152, b_y=45 → bomb_x=159, bomb_y=50. Player movement after placement does not change bomb_x or e_x.
- Held button and re-press:
  - c held high for 30 cycles → exactly one bomb.
  - A press during ARMED (macro off) → no change in timing.
  - A press during EXPLODE → no new bomb.
  - A press on the first IDLE cycle → accepted.
- game_over:
  - game_over=1 in IDLE, then press → stays IDLE, no pulse.
  - game_over rising mid-ARMED → explosion still occurs at cycle 10.
- Reset mid-ARMED at cycle 5 → all outputs at reset values at once; no explosion_scen ever emitted for that bomb.
- Macro on: press at cycle 3 of ARMED → explosion_scen on the following cycle; EXPLODE lasts 4 cycles.
